b_lut_opfetch: RTL and testbench
================================

# b_lut_opfetch

Operand-gather stage that sits directly upstream of the `xc.lut` combinational core. The core needs three 32-bit source operands (LUT input, LUT bottom half, LUT top half), but the register file offers only two read ports. This block accepts an issued `xc.lut` with a valid/ready handshake and reads the three registers over two cycles. It then holds `crs1`/`crs2`/`crs3` stable under a valid/ready handshake until the downstream LUT/writeback stage consumes them.

## Interface
Parameters:
- `XLEN`, 32, operand width.
- `RA_W`, 5, register address width.

Ports:
- `g_clk`  in  1  clock; all state changes on its rising edge.
- `g_reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush; abandons any in-flight operation.
- `issue_valid`  in  1  an `xc.lut` is offered.
- `issue_ready`  out  1  block accepts an issue this cycle.
- `issue_rs1`, `issue_rs2`, `issue_rs3`  in  RA_W each  source register addresses.
- `issue_rd`  in  RA_W  destination address; passed through unchanged.
- `rf_addr_a`, `rf_addr_b`  out  RA_W each  register-file read addresses.
- `rf_rdata_a`, `rf_rdata_b`  in  XLEN each  register-file read data, combinational, same cycle as address.
- `op_valid`  out  1  operands are presented.
- `op_ready`  in  1  downstream consumes the operands.
- `op_crs1`, `op_crs2`, `op_crs3`  out  XLEN each  gathered operands.
- `op_rd`  out  RA_W  destination address of the presented operation.

## Operation
- FSM has three states: IDLE, READ2, HOLD. Encoding is free, but unused encodings must return to IDLE.
- **IDLE**
  - `issue_ready = !flush`.
  - `rf_addr_a = issue_rs1` and `rf_addr_b = issue_rs2`, driven combinationally.
  - On `issue_valid && issue_ready`: capture `crs1 ← rdata_a` and `crs2 ← rdata_b`, latch `rs3` and `rd`, then go to READ2.
- **READ2**
  - `rf_addr_a` = latched `rs3`; `rf_addr_b = 0`.
  - Capture `crs3 ← rdata_a`, then go to HOLD.
- **HOLD**
  - `op_valid = 1`; `rf_addr_a = rf_addr_b = 0`.
  - On `op_ready`, go to IDLE.
- **x0 handling:** a source address of 0 always yields operand 0, regardless of `rf_rdata_*`. The block forces this; it does not rely on the register file.
- **Output stability:** `op_crs1`/`op_crs2`/`op_crs3`/`op_rd` are registers. They must not change while `op_valid=1 && !op_ready`.
- **Flush:** in any state, the next state is IDLE. No capture occurs in the flush cycle. Operand registers need not be cleared, but `op_valid` must be 0 from the next cycle.
- **Reset:** state IDLE. `op_valid=0`, `op_crs1`/`op_crs2`/`op_crs3=0`, `op_rd=0`, and `issue_ready=1` in the cycle after reset deasserts.
- **Priority:** `g_reset` > `flush` > handshakes.
- No arithmetic is performed; widths pass through unchanged.

## Timing
- Issue accepted at edge N → READ2 during cycle N+1 → `op_valid=1` from cycle N+2.
- Minimum occupancy is 3 cycles per operation, so peak throughput is 1 op / 3 cycles.
- `issue_ready` is high only in IDLE. No new issue is accepted in the cycle `op_ready` is sampled in HOLD; the next issue can be accepted one cycle later.
- `op_valid` is a registered output: it is high exactly while in HOLD.
- `issue_ready` and `rf_addr_*` are combinational from state and issue inputs. There is no combinational path from `op_ready` to `issue_ready`.
- **Reset mid-operation:** if asserted in READ2 or HOLD, `op_valid` is 0 in the following cycle and the operation is lost.
- **Flush + `issue_valid` in IDLE:** the issue is not accepted.
- **Flush + `op_ready` in HOLD:** the result is the same either way (IDLE); the consumer treats it as accepted only if its own flush rules allow.

## Test plan
- **Basic gather:** RF x1=0x01234567, x2=0x89ABCDEF, x3=0xFEDCBA98; issue rs1=1, rs2=2, rs3=3, rd=7 with `op_ready=1`. Required response:
  - addresses (1,2) at N and (3,0) at N+1;
  - `op_valid` for exactly cycle N+2, carrying 0x01234567 / 0x89ABCDEF / 0xFEDCBA98 and rd=7;
  - `issue_ready` back to 1 at N+3.
- **Backpressure:** same issue with `op_ready=0` for 5 cycles. Required: `op_valid` held and operands unchanged for all 5 cycles; a second `issue_valid` is not accepted; completes on the first `op_ready=1`.
- **x0 forcing:** rs1=0, rs2=0, rs3=0, with the RF model driving 0xDEADBEEF on both ports. Required: all operands = 0.
- **Flush:** flush asserted in READ2. Required: `op_valid` stays 0 and `issue_ready=1` the next cycle. A following issue rs1=2, rs2=3, rs3=1 then produces 0x89ABCDEF / 0xFEDCBA98 / 0x01234567.
- **Reset mid-HOLD:** `g_reset` asserted for 1 cycle while `op_valid=1`. Required: all outputs read 0 and `issue_ready=1` in the following cycle.
- **Back-to-back stream:** 20 random issues with random `op_ready`. Required: a scoreboard confirms in-order, loss-free delivery, and throughput never better than 1 op / 3 cycles.

Source files
------------

// File: rtl/b_lut_opfetch.sv
// b_lut_opfetch
//   Operand-gather stage in front of the xc.lut combinational core. The core
//   needs three source operands, but the register file has only two read
//   ports. This block accepts one issue, reads rs1/rs2 in the issue cycle and
//   rs3 in the following cycle. It then presents crs1/crs2/crs3 and rd under a
//   valid/ready handshake until the consumer takes them.
//
// Ports
//   g_clk, g_reset        clock and synchronous active-high reset
//   flush                 abandons any in-flight operation (next state IDLE)
//   issue_valid/ready     issue handshake; ready only in IDLE and not flushing
//   issue_rs1/2/3, rd     source and destination register addresses
//   rf_addr_a/b           register-file read addresses (combinational)
//   rf_rdata_a/b          register-file read data (same cycle as address)
//   op_valid/ready        operand handshake towards the LUT/writeback stage
//   op_crs1/2/3, op_rd    gathered operands and destination, registered
module b_lut_opfetch #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [RA_W-1:0] issue_rs1,
  input  logic [RA_W-1:0] issue_rs2,
  input  logic [RA_W-1:0] issue_rs3,
  input  logic [RA_W-1:0] issue_rd,
  output logic [RA_W-1:0] rf_addr_a,
  output logic [RA_W-1:0] rf_addr_b,
  input  logic [XLEN-1:0] rf_rdata_a,
  input  logic [XLEN-1:0] rf_rdata_b,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [XLEN-1:0] op_crs1,
  output logic [XLEN-1:0] op_crs2,
  output logic [XLEN-1:0] op_crs3,
  output logic [RA_W-1:0] op_rd
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ2 = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] crs1_q, crs1_d;
  logic [XLEN-1:0] crs2_q, crs2_d;
  logic [XLEN-1:0] crs3_q, crs3_d;
  logic [RA_W-1:0] rs3_q, rs3_d;
  logic [RA_W-1:0] rd_q, rd_d;

  always_comb begin
    state_d     = state_q;
    crs1_d      = crs1_q;
    crs2_d      = crs2_q;
    crs3_d      = crs3_q;
    rs3_d       = rs3_q;
    rd_d        = rd_q;
    issue_ready = 1'b0;
    rf_addr_a   = '0;
    rf_addr_b   = '0;

    case (state_q)
      ST_IDLE: begin
        issue_ready = !flush;
        rf_addr_a   = issue_rs1;
        rf_addr_b   = issue_rs2;
        if (issue_valid && !flush) begin
          // x0 is forced to zero here rather than trusting the register file.
          crs1_d  = (issue_rs1 == '0) ? '0 : rf_rdata_a;
          crs2_d  = (issue_rs2 == '0) ? '0 : rf_rdata_b;
          rs3_d   = issue_rs3;
          rd_d    = issue_rd;
          state_d = ST_READ2;
        end
      end
      ST_READ2: begin
        rf_addr_a = rs3_q;
        if (!flush) begin
          crs3_d  = (rs3_q == '0) ? '0 : rf_rdata_a;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Operand registers are not touched here, so they stay stable while
        // the consumer stalls.
        if (op_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      crs1_q  <= '0;
      crs2_q  <= '0;
      crs3_q  <= '0;
      rs3_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      crs1_q  <= crs1_d;
      crs2_q  <= crs2_d;
      crs3_q  <= crs3_d;
      rs3_q   <= rs3_d;
      rd_q    <= rd_d;
    end
  end

  // op_valid comes straight from the state register, so there is no
  // combinational path from op_ready to any output.
  assign op_valid = (state_q == ST_HOLD);
  assign op_crs1  = crs1_q;
  assign op_crs2  = crs2_q;
  assign op_crs3  = crs3_q;
  assign op_rd    = rd_q;

endmodule

// File: tb/tb_b_lut_opfetch.sv
module tb_b_lut_opfetch;

  logic        g_clk = 1'b0;
  logic        g_reset, flush, issue_valid, op_ready;
  logic        issue_ready, op_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rs3, issue_rd;
  logic [4:0]  rf_addr_a, rf_addr_b, op_rd;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic [31:0] op_crs1, op_crs2, op_crs3;

  logic [31:0] rf [32];
  logic        rf_poison;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rs1, rs2, rs3, rd;
    logic        poison;
    logic [31:0] e1, e2, e3;
  } vec_t;

  typedef struct {
    logic [31:0] c1, c2, c3;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  always #5 g_clk = ~g_clk;

  always_comb rf_rdata_a = rf_poison ? 32'hDEADBEEF : rf[rf_addr_a];
  always_comb rf_rdata_b = rf_poison ? 32'hDEADBEEF : rf[rf_addr_b];

  b_lut_opfetch #(.XLEN(32), .RA_W(5)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
    .issue_rd(issue_rd),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_crs1(op_crs1), .op_crs2(op_crs2), .op_crs3(op_crs3), .op_rd(op_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  // Architectural read: x0 is zero, everything else comes from the file.
  function automatic logic [31:0] arch_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  task automatic drive_issue(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rs3, input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rs1 = rs1; issue_rs2 = rs2; issue_rs3 = rs3; issue_rd = rd;
  endtask

  // One cycle-exact operation with op_ready held high.
  task automatic run_op(input vec_t v);
    @(posedge g_clk); #1;
    drive_issue(v.rs1, v.rs2, v.rs3, v.rd);
    op_ready  = 1'b1;
    rf_poison = v.poison;
    @(negedge g_clk);
    chk("N issue_ready", 32'(issue_ready), 32'd1);
    chk("N rf_addr_a", 32'(rf_addr_a), 32'(v.rs1));
    chk("N rf_addr_b", 32'(rf_addr_b), 32'(v.rs2));
    @(posedge g_clk); #1;
    issue_valid = 1'b0;
    issue_rs1 = 5'(~v.rs1); issue_rs2 = 5'(~v.rs2); issue_rs3 = 5'(~v.rs3);
    @(negedge g_clk);
    chk("N+1 op_valid", 32'(op_valid), 32'd0);
    chk("N+1 issue_ready", 32'(issue_ready), 32'd0);
    chk("N+1 rf_addr_a", 32'(rf_addr_a), 32'(v.rs3));
    chk("N+1 rf_addr_b", 32'(rf_addr_b), 32'd0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("N+2 op_valid", 32'(op_valid), 32'd1);
    chk("N+2 crs1", op_crs1, v.e1);
    chk("N+2 crs2", op_crs2, v.e2);
    chk("N+2 crs3", op_crs3, v.e3);
    chk("N+2 rd", 32'(op_rd), 32'(v.rd));
    chk("N+2 rf_addr_a", 32'(rf_addr_a), 32'd0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("N+3 op_valid", 32'(op_valid), 32'd0);
    chk("N+3 issue_ready", 32'(issue_ready), 32'd1);
    rf_poison = 1'b0;
  endtask

  initial begin
    vec_t v;
    int issued, delivered, cyc, last_acc;
    logic prev_hold;
    exp_t saved, e;

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0]  = 32'h5A5A5A5A;   // nonzero on purpose: the block must force x0
    rf[1]  = 32'h01234567;
    rf[2]  = 32'h89ABCDEF;
    rf[3]  = 32'hFEDCBA98;
    rf[5]  = 32'h13579BDF;
    rf[31] = 32'hCAFEF00D;

    vecs[0] = '{5'd1,  5'd2,  5'd3,  5'd7,  1'b0, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};
    vecs[1] = '{5'd0,  5'd0,  5'd0,  5'd4,  1'b1, 32'h0, 32'h0, 32'h0};
    vecs[2] = '{5'd3,  5'd0,  5'd31, 5'd31, 1'b0, 32'hFEDCBA98, 32'h0, 32'hCAFEF00D};
    vecs[3] = '{5'd0,  5'd5,  5'd0,  5'd1,  1'b0, 32'h0, 32'h13579BDF, 32'h0};
    vecs[4] = '{5'd31, 5'd31, 5'd1,  5'd0,  1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h01234567};
    vecs[5] = '{5'd5,  5'd1,  5'd2,  5'd2,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};

    g_reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; op_ready = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rs3 = '0; issue_rd = '0;
    rf_poison = 1'b0;
    repeat (3) @(posedge g_clk);
    #1 g_reset = 1'b0;
    @(negedge g_clk);
    chk("reset op_valid", 32'(op_valid), 32'd0);
    chk("reset crs1", op_crs1, 32'd0);
    chk("reset crs2", op_crs2, 32'd0);
    chk("reset crs3", op_crs3, 32'd0);
    chk("reset rd", 32'(op_rd), 32'd0);
    chk("reset issue_ready", 32'(issue_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      $display("vector %0d rs=%0d,%0d,%0d rd=%0d", i, vecs[i].rs1, vecs[i].rs2, vecs[i].rs3, vecs[i].rd);
      run_op(vecs[i]);
    end

    // Backpressure: hold for 5 cycles while a second issue is offered.
    @(posedge g_clk); #1;
    drive_issue(5'd1, 5'd2, 5'd3, 5'd7);
    op_ready = 1'b0;
    @(posedge g_clk); #1;
    drive_issue(5'd3, 5'd3, 5'd3, 5'd9);
    @(posedge g_clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge g_clk);
      chk("bp op_valid", 32'(op_valid), 32'd1);
      chk("bp issue_ready", 32'(issue_ready), 32'd0);
      chk("bp crs1", op_crs1, 32'h01234567);
      chk("bp crs2", op_crs2, 32'h89ABCDEF);
      chk("bp crs3", op_crs3, 32'hFEDCBA98);
      chk("bp rd", 32'(op_rd), 32'd7);
      @(posedge g_clk); #1;
    end
    op_ready = 1'b1; issue_valid = 1'b0;
    @(negedge g_clk);
    chk("bp release op_valid", 32'(op_valid), 32'd1);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("bp done op_valid", 32'(op_valid), 32'd0);
    chk("bp done issue_ready", 32'(issue_ready), 32'd1);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("bp 2nd not accepted", 32'(op_valid), 32'd0);
    $display("backpressure sequence done");

    // Flush in READ2.
    @(posedge g_clk); #1;
    drive_issue(5'd1, 5'd2, 5'd3, 5'd6);
    @(posedge g_clk); #1;
    issue_valid = 1'b0; flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0;
    @(negedge g_clk);
    chk("flush op_valid", 32'(op_valid), 32'd0);
    chk("flush issue_ready", 32'(issue_ready), 32'd1);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("flush op_valid+1", 32'(op_valid), 32'd0);
    v = '{5'd2, 5'd3, 5'd1, 5'd12, 1'b0, 32'h89ABCDEF, 32'hFEDCBA98, 32'h01234567};
    run_op(v);
    $display("flush-in-READ2 sequence done");

    // Flush together with issue_valid in IDLE: issue must be refused.
    @(posedge g_clk); #1;
    drive_issue(5'd1, 5'd1, 5'd1, 5'd1);
    flush = 1'b1;
    @(negedge g_clk);
    chk("flush+issue ready", 32'(issue_ready), 32'd0);
    @(posedge g_clk); #1;
    flush = 1'b0; issue_valid = 1'b0;
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    chk("flush+issue no op", 32'(op_valid), 32'd0);
    $display("flush-with-issue sequence done");

    // Reset while in HOLD.
    @(posedge g_clk); #1;
    drive_issue(5'd1, 5'd2, 5'd3, 5'd7);
    op_ready = 1'b0;
    @(posedge g_clk); #1;
    issue_valid = 1'b0;
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("pre-reset op_valid", 32'(op_valid), 32'd1);
    @(posedge g_clk); #1;
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    @(negedge g_clk);
    chk("midreset op_valid", 32'(op_valid), 32'd0);
    chk("midreset crs1", op_crs1, 32'd0);
    chk("midreset crs2", op_crs2, 32'd0);
    chk("midreset crs3", op_crs3, 32'd0);
    chk("midreset rd", 32'(op_rd), 32'd0);
    chk("midreset issue_ready", 32'(issue_ready), 32'd1);
    $display("reset-in-HOLD sequence done");

    // Random stream against a queue scoreboard.
    for (int i = 4; i < 8; i++) rf[i] = $urandom;
    issued = 0; delivered = 0; cyc = 0; last_acc = -100; prev_hold = 1'b0;
    saved = '{32'd0, 32'd0, 32'd0, 5'd0};
    while (delivered < 20 && cyc < 3000) begin
      @(posedge g_clk); #1;
      issue_valid = (issued < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      issue_rs1 = 5'($urandom_range(0, 7));
      issue_rs2 = 5'($urandom_range(0, 7));
      issue_rs3 = 5'($urandom_range(0, 7));
      issue_rd  = 5'($urandom_range(0, 31));
      op_ready  = 1'($urandom_range(0, 1));
      @(negedge g_clk);
      cyc++;
      if (issue_ready && op_valid) chk("stream ready-in-hold", 32'd1, 32'd0);
      if (prev_hold) begin
        chk("stream hold valid", 32'(op_valid), 32'd1);
        chk("stream hold crs1", op_crs1, saved.c1);
        chk("stream hold crs2", op_crs2, saved.c2);
        chk("stream hold crs3", op_crs3, saved.c3);
        chk("stream hold rd", 32'(op_rd), 32'(saved.rd));
      end
      if (issue_valid && issue_ready) begin
        if (cyc - last_acc < 3) chk("stream issue spacing", 32'(cyc - last_acc), 32'd3);
        last_acc = cyc;
        sb.push_back('{arch_read(issue_rs1), arch_read(issue_rs2),
                       arch_read(issue_rs3), issue_rd});
        issued++;
      end
      if (op_valid && op_ready) begin
        if (sb.size() == 0) begin
          chk("stream unexpected op", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("stream crs1", op_crs1, e.c1);
          chk("stream crs2", op_crs2, e.c2);
          chk("stream crs3", op_crs3, e.c3);
          chk("stream rd", 32'(op_rd), 32'(e.rd));
          $display("stream op %0d delivered rd=%0d at cycle %0d", delivered, op_rd, cyc);
        end
        delivered++;
      end
      prev_hold = op_valid && !op_ready;
      saved = '{op_crs1, op_crs2, op_crs3, op_rd};
    end
    chk("stream delivered count", 32'(delivered), 32'd20);
    chk("stream scoreboard empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
